toggle_event_rx: RTL and testbench
==================================

// Module: toggle_event_rx
// PURPOSE
// - Multi-channel receive side of a toggle-based event crossing. Runs entirely in the destination clock domain.
// - Each tog_in bit is a level that flips once per source event, driven from an unrelated clock.
// - Per channel: synchronise through a parametrised flop chain, detect each toggle, count pending events.
// - Present pending events one at a time on a valid/ready stream, round-robin across channels, with sticky per-channel overflow.
// PARAMETERS
// - CHANNELS    4  number of independent toggle channels (>=1)
// - SYNC_STAGES 2  synchroniser flops per channel (>=2)
// - CNT_W       4  pending-event counter width; saturates at 2**CNT_W-1
// - CH_W        derived = max(1,clog2(CHANNELS)); not user-set
// PORTS
// - clk          in   1         destination clock; only clock in the block
// - reset        in   1         synchronous, active-high reset
// - tog_in       in   CHANNELS  asynchronous toggle levels, one per channel
// - evt_valid    out  1         an event is presented on evt_chan
// - evt_ready    in   1         consumer accepts the event when high with evt_valid
// - evt_chan     out  CH_W      channel index of the presented event
// - evt_pulse    out  CHANNELS  one-cycle pulse per detected toggle (raw, unqueued)
// - overflow     out  CHANNELS  sticky: event lost on a saturated counter
// - ovf_clr      in   1         clears all overflow bits
// - pending_any  out  1         OR of (pend[i]!=0) across channels
// BEHAVIOUR
// - Reset values:
//   - evt_valid=0, evt_chan=0, evt_pulse=0, overflow=0, pending_any=0.
//   - Counters = 0. Round-robin pointer = CHANNELS-1, so ch0 has first priority.
// - Synchroniser and history flops:
//   - Sync flops have no reset.
//   - During reset, the history flop prev[i] loads the last sync stage, so a high tog_in at reset release causes no false event.
//   - Reset must be held for >= SYNC_STAGES+1 cycles.
// - Edge detect: det[i] = sync_last[i] ^ prev[i]. prev[i] <= sync_last[i] every cycle.
// - Latency:
//   - tog_in change set up before edge k: sync_last changes at edge k+SYNC_STAGES-1.
//   - At edge k+SYNC_STAGES: evt_pulse[i]=1 for exactly one cycle, and pend[i] increments.
//   - evt_valid rises at edge k+SYNC_STAGES+1 if the output slot is free.
// - Counter pend[i]:
//   - +1 on det[i].
//   - -1 when channel i is loaded into the output slot.
//   - Both in the same cycle: value unchanged.
//   - det[i] with pend[i] at max and no simultaneous load: count holds, event is dropped, overflow[i]<=1.
// - Overflow:
//   - ovf_clr clears all bits.
//   - A set and a clear on the same bit in the same cycle: set wins.
// - Output slot: loads when (!evt_valid || evt_ready).
//   - Picks the first channel with pend!=0, searching from ptr+1 upward with wrap.
//   - Registers evt_chan and evt_valid=1, updates ptr to the granted channel, decrements that counter.
//   - No candidate: evt_valid<=0.
// - Throughput: back-to-back acceptance gives one event per cycle.
// - Stability: while evt_valid && !evt_ready, evt_chan holds stable.
// - pending_any: registered from the counter values after update. Does not include the occupied output slot.
// - Source constraint (documented, not checked): minimum toggle spacing is SYNC_STAGES+1 destination cycles. Closer toggles merge or are lost.
// - Reset mid-operation: all pending events, the presented event and overflow are discarded. No pulse or valid appears in the cycle after reset deasserts.
// STRUCTURE
// - Shared package/header toggle_rx_pkg:
//   - clog2 function and CH_W derivation.
//   - SYNC_STAGES_MIN=2 constant, with an elaboration check on parameters.
// - Sub-module sync_nff (width 1, STAGES parameter, no reset), one instance per channel via generate.
// - Top level holds: history/edge detect, counter array, round-robin arbiter, output register.
// TESTING
// - Single event: reset 4 cycles, then toggle tog_in[2] 0->1.
//   - Expect evt_pulse[2] for 1 cycle at edge +2 (SYNC_STAGES=2).
//   - Expect evt_valid with evt_chan=2 at edge +3. evt_ready=1 -> evt_valid drops next cycle.
// - Reset release with tog_in=4'b1111 held: no evt_pulse, no evt_valid, pending_any=0 for 20 cycles.
// - Round-robin: one toggle each on ch0..ch3 in the same cycle, evt_ready=1.
//   - Expect evt_chan sequence 0,1,2,3 on consecutive cycles.
//   - Then toggle ch1 and ch0 together -> order 0,1.
// - Backpressure: evt_ready=0, toggle ch1 three times, 4 cycles apart.
//   - evt_chan=1 is held stable.
//   - After ready goes high: 3 accepts total, then evt_valid=0.
// - Overflow (CNT_W=2): evt_ready=0, 6 toggles on ch0.
//   - Output slot holds 1, pend saturates at 3, overflow[0]=1.
//   - ovf_clr -> overflow=0. Exactly 4 events are delivered.
// - Simultaneous inc/dec, and reset mid-stream:
//   - Toggle arriving in the cycle its channel is granted leaves pend unchanged and is delivered later.
//   - Assert reset with 2 pending -> all outputs 0 after reset deasserts.

Source files
------------

// File: rtl/toggle_rx_pkg.sv
// Shared constants and helpers for the toggle event receiver.
// Provides clog2, channel-index width derivation and the synchroniser depth floor.
package toggle_rx_pkg;

  localparam int SYNC_STAGES_MIN = 2;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int ch_width(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/toggle_event_rx_sync.sv
// Single-bit N-flop synchroniser with no reset.
// Ports: clk, d (async input), q (synchronised output).
module sync_nff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff_q;
  logic [STAGES-1:0] ff_d;

  always_comb begin
    ff_d = {ff_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    ff_q <= ff_d;
  end

  assign q = ff_q[STAGES-1];

endmodule

// File: rtl/toggle_event_rx.sv
// Multi-channel toggle event receiver: sync, edge detect, pending counters,
// round-robin valid/ready output. Ports: clk, reset, tog_in, evt_*, overflow,
// ovf_clr, pending_any.
module toggle_event_rx
  import toggle_rx_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4,
  localparam int CH_W       = ch_width(CHANNELS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] tog_in,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [CH_W-1:0]     evt_chan,
  output logic [CHANNELS-1:0] evt_pulse,
  output logic [CHANNELS-1:0] overflow,
  input  logic                ovf_clr,
  output logic                pending_any
);

  if (SYNC_STAGES < SYNC_STAGES_MIN || CHANNELS < 1 || CNT_W < 1) begin : g_bad
    $error("toggle_event_rx: illegal parameters");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CHANNELS-1:0] sync_last;
  logic [CHANNELS-1:0] det;
  logic [CHANNELS-1:0] prev_q, prev_d;
  logic [CHANNELS-1:0] pulse_q, pulse_d;
  logic [CHANNELS-1:0] ovf_q, ovf_d;
  logic [CHANNELS-1:0] ovf_set;
  logic [CNT_W-1:0]    pend_q [CHANNELS];
  logic [CNT_W-1:0]    pend_d [CHANNELS];
  logic [CH_W-1:0]     ptr_q, ptr_d;
  logic [CH_W-1:0]     chan_q, chan_d;
  logic                valid_q, valid_d;
  logic                pany_q, pany_d;
  logic                grant_vld;
  logic [CH_W-1:0]     grant_ch;
  logic                load_en;
  logic                load;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_sync
    sync_nff #(.STAGES(SYNC_STAGES)) u_sync (
      .clk (clk),
      .d   (tog_in[g]),
      .q   (sync_last[g])
    );
  end

  assign det = sync_last ^ prev_q;

  // Round-robin: first non-empty channel after the last grant.
  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_ch  = '0;
    for (int o = 1; o <= CHANNELS; o++) begin
      idx = (int'(ptr_q) + o) % CHANNELS;
      if (!grant_vld && pend_q[idx] != '0) begin
        grant_vld = 1'b1;
        grant_ch  = CH_W'(idx);
      end
    end
  end

  assign load_en = !valid_q || evt_ready;
  assign load    = load_en && grant_vld;

  // A detect and a grant in the same cycle cancel out.
  always_comb begin
    logic take;
    take    = 1'b0;
    ovf_set = '0;
    pany_d  = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      pend_d[i] = pend_q[i];
      take      = load && (grant_ch == CH_W'(i));
      if (det[i] && !take) begin
        if (pend_q[i] == CNT_MAX) ovf_set[i] = 1'b1;
        else pend_d[i] = pend_q[i] + 1'b1;
      end else if (take && !det[i]) begin
        pend_d[i] = pend_q[i] - 1'b1;
      end
      if (pend_d[i] != '0) pany_d = 1'b1;
    end
  end

  always_comb begin
    prev_d  = sync_last;
    pulse_d = det;
    ovf_d   = (ovf_clr ? '0 : ovf_q) | ovf_set;
    valid_d = valid_q;
    chan_d  = chan_q;
    ptr_d   = ptr_q;
    if (load_en) begin
      valid_d = grant_vld;
      if (grant_vld) begin
        chan_d = grant_ch;
        ptr_d  = grant_ch;
      end
    end
  end

  // History tracks sync output during reset too, so a
  // level already high at release is not an event.
  always_ff @(posedge clk) begin
    prev_q <= prev_d;
    if (reset) begin
      pulse_q <= '0;
      ovf_q   <= '0;
      valid_q <= 1'b0;
      chan_q  <= '0;
      ptr_q   <= CH_W'(CHANNELS - 1);
      pany_q  <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) pend_q[i] <= '0;
    end else begin
      pulse_q <= pulse_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      chan_q  <= chan_d;
      ptr_q   <= ptr_d;
      pany_q  <= pany_d;
      for (int i = 0; i < CHANNELS; i++) pend_q[i] <= pend_d[i];
    end
  end

  assign evt_valid   = valid_q;
  assign evt_chan    = chan_q;
  assign evt_pulse   = pulse_q;
  assign overflow    = ovf_q;
  assign pending_any = pany_q;

endmodule

// File: tb/tb_toggle_event_rx.sv
// Scoreboard bench for toggle_event_rx (4 channels, 2 sync stages,
// 2-bit counters so saturation is reachable).
module tb_toggle_event_rx;

  localparam int CH  = 4;
  localparam int SS  = 2;
  localparam int CW  = 2;
  localparam int CHW = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [CH-1:0]  tog_in = '0;
  logic           evt_ready = 1'b0;
  logic           ovf_clr = 1'b0;
  logic           evt_valid;
  logic [CHW-1:0] evt_chan;
  logic [CH-1:0]  evt_pulse;
  logic [CH-1:0]  overflow;
  logic           pending_any;

  int n_chk  = 0;
  int n_pass = 0;
  int exp_q[$];

  toggle_event_rx #(
    .CHANNELS(CH), .SYNC_STAGES(SS), .CNT_W(CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tog_in     (tog_in),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_chan   (evt_chan),
    .evt_pulse  (evt_pulse),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr),
    .pending_any(pending_any)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted event is checked against the scoreboard.
  always @(negedge clk) begin
    if (!reset && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_chan", int'(evt_chan), -1);
      end else begin
        chk("sb_evt_chan", int'(evt_chan), exp_q.pop_front());
      end
    end
  end

  initial begin
    // reset state and single event on ch2
    step(4);
    @(negedge clk);
    chk("rst_valid", evt_valid, 0);
    chk("rst_chan", evt_chan, 0);
    chk("rst_pulse", evt_pulse, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_pany", pending_any, 0);
    step();
    reset = 1'b0;
    step();
    evt_ready = 1'b1;
    tog_in[2] = 1'b1;
    exp_q.push_back(2);
    step(2);
    @(negedge clk);
    chk("single_pulse_early", evt_pulse, 0);
    step();
    @(negedge clk);
    chk("single_pulse", evt_pulse, 4);
    chk("single_pany", pending_any, 1);
    chk("single_valid_early", evt_valid, 0);
    step();
    @(negedge clk);
    chk("single_pulse_gone", evt_pulse, 0);
    chk("single_valid", evt_valid, 1);
    chk("single_chan", evt_chan, 2);
    chk("single_pany_clr", pending_any, 0);
    step();
    @(negedge clk);
    chk("single_valid_drop", evt_valid, 0);

    // reset release with all levels high
    step();
    reset  = 1'b1;
    tog_in = 4'b1111;
    step(4);
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      @(negedge clk);
      chk("relhi_pulse", evt_pulse, 0);
      chk("relhi_valid", evt_valid, 0);
      chk("relhi_pany", pending_any, 0);
    end

    // round robin: all four at once, then ch1+ch0
    step();
    tog_in = 4'b0000;
    for (int i = 0; i < 4; i++) exp_q.push_back(i);
    step(10);
    @(negedge clk);
    chk("rr4_valid_end", evt_valid, 0);
    chk("rr4_drained", exp_q.size(), 0);
    step();
    tog_in[1:0] = 2'b11;
    exp_q.push_back(0);
    exp_q.push_back(1);
    step(10);
    @(negedge clk);
    chk("rr2_drained", exp_q.size(), 0);

    // backpressure on ch1
    step();
    evt_ready = 1'b0;
    for (int t = 0; t < 3; t++) begin
      tog_in[1] = ~tog_in[1];
      exp_q.push_back(1);
      for (int c = 0; c < 4; c++) begin
        step();
        @(negedge clk);
        if (evt_valid) chk("bp_chan_stable", evt_chan, 1);
      end
    end
    step(3);
    @(negedge clk);
    chk("bp_valid_held", evt_valid, 1);
    chk("bp_chan_held", evt_chan, 1);
    chk("bp_pany", pending_any, 1);
    step();
    evt_ready = 1'b1;
    step(5);
    @(negedge clk);
    chk("bp_valid_end", evt_valid, 0);
    chk("bp_drained", exp_q.size(), 0);

    // overflow: six toggles on ch0 against 2-bit counters
    step();
    evt_ready = 1'b0;
    for (int t = 0; t < 6; t++) begin
      tog_in[0] = ~tog_in[0];
      if (t < 4) exp_q.push_back(0);
      step(4);
      if (t == 3) begin
        @(negedge clk);
        chk("ovf_not_yet", overflow, 0);
      end
    end
    @(negedge clk);
    chk("ovf_set", overflow, 1);
    chk("ovf_pany", pending_any, 1);
    step();
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    @(negedge clk);
    chk("ovf_cleared", overflow, 0);
    evt_ready = 1'b1;
    step(8);
    @(negedge clk);
    chk("ovf_valid_end", evt_valid, 0);
    chk("ovf_four_delivered", exp_q.size(), 0);

    // simultaneous increment and grant on ch2
    step();
    evt_ready = 1'b0;
    tog_in[2] = ~tog_in[2];
    exp_q.push_back(2);
    step(4);
    tog_in[2] = ~tog_in[2];
    exp_q.push_back(2);
    step(4);
    tog_in[2] = ~tog_in[2];
    exp_q.push_back(2);
    step(2);
    evt_ready = 1'b1;
    step();
    @(negedge clk);
    chk("incdec_valid", evt_valid, 1);
    chk("incdec_chan", evt_chan, 2);
    chk("incdec_pany", pending_any, 1);
    step(4);
    @(negedge clk);
    chk("incdec_valid_end", evt_valid, 0);
    chk("incdec_pany_end", pending_any, 0);
    chk("incdec_drained", exp_q.size(), 0);

    // reset with events pending and one presented
    step();
    evt_ready = 1'b0;
    tog_in[0] = ~tog_in[0];
    tog_in[1] = ~tog_in[1];
    tog_in[3] = ~tog_in[3];
    step(5);
    @(negedge clk);
    chk("mid_valid", evt_valid, 1);
    chk("mid_pany", pending_any, 1);
    step();
    reset = 1'b1;
    step(4);
    reset     = 1'b0;
    evt_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      @(negedge clk);
      chk("post_rst_valid", evt_valid, 0);
      chk("post_rst_pulse", evt_pulse, 0);
      chk("post_rst_pany", pending_any, 0);
      chk("post_rst_ovf", overflow, 0);
    end

    chk("sb_final_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
